// File: rtl/arith_pkg.sv
// Shared arithmetic types and defaults for the adder/subtractor datapath.
package arith_pkg;

  localparam int unsigned DEFAULT_WIDTH = 64;

  typedef struct packed {
    logic bout;
    logic zero;
    logic neg;
    logic ovf;
  } arith_flags_t;

endpackage

// File: rtl/bk_prefix_net.sv
// Brent-Kung prefix carry network: up-sweep then down-sweep over (g, p),
// with cin folded into bit 0 so every group generate is a carry.
module bk_prefix_net
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] p,
  input  logic             cin,
  output logic [WIDTH:0]   carry
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int NL     = 2 * LEVELS - 1;

  logic [WIDTH-1:0] gs [0:NL];
  logic [WIDTH-1:0] ps [0:NL-1];

  assign gs[0] = {g[WIDTH-1:1], g[0] | (p[0] & cin)};
  assign ps[0] = p;

  // Levels 1..LEVELS form the up-sweep; the rest fill in the gaps top-down.
  for (genvar lvl = 1; lvl <= NL; lvl++) begin : g_level
    localparam int K    = (lvl <= LEVELS) ? lvl : 2 * LEVELS - lvl;
    localparam int SPAN = 1 << K;
    localparam int D    = SPAN / 2;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      localparam bit COMB = (lvl <= LEVELS) ? (((i + 1) % SPAN) == 0)
                                            : ((((i + 1) % SPAN) == D) && (i >= SPAN));
      if (COMB) begin : g_op
        assign gs[lvl][i] = gs[lvl-1][i] | (ps[lvl-1][i] & gs[lvl-1][i-D]);
        if (lvl < NL) begin : g_p
          assign ps[lvl][i] = ps[lvl-1][i] & ps[lvl-1][i-D];
        end
      end else begin : g_pass
        assign gs[lvl][i] = gs[lvl-1][i];
        if (lvl < NL) begin : g_p
          assign ps[lvl][i] = ps[lvl-1][i];
        end
      end
    end
  end

  assign carry = {gs[NL], cin};

endmodule

// File: rtl/brent_kung_sub_pipe.sv
// Two-stage pipelined subtractor diff = a - b - bin on a Brent-Kung carry
// network, with valid/ready handshake and borrow/zero/neg/overflow flags.
module brent_kung_sub_pipe
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  logic             adv;
  logic             v1, v2;
  logic [WIDTH-1:0] g1, p1;
  logic             a_msb1, b_msb1, cin1;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  arith_flags_t     flags_d, flags_q;
  logic [WIDTH-1:0] diff_q;

  // A stall freezes both stages together; bubbles are not squeezed out.
  assign adv = !v2 || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else if (adv) begin
      v1 <= in_valid;
      v2 <= v1;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      g1     <= a & ~b;
      p1     <= a ^ ~b;
      a_msb1 <= a[WIDTH-1];
      b_msb1 <= b[WIDTH-1];
      cin1   <= ~bin;
      diff_q  <= sum;
      flags_q <= flags_d;
    end
  end

  bk_prefix_net #(.WIDTH(WIDTH)) u_prefix (
    .g     (g1),
    .p     (p1),
    .cin   (cin1),
    .carry (carry)
  );

  assign sum = p1 ^ carry[WIDTH-1:0];

  always_comb begin
    flags_d      = '0;
    flags_d.bout = ~carry[WIDTH];
    flags_d.zero = (sum == '0);
    flags_d.neg  = sum[WIDTH-1];
    flags_d.ovf  = (a_msb1 != b_msb1) && (sum[WIDTH-1] != a_msb1);
  end

  assign in_ready  = adv;
  assign out_valid = v2;
  assign diff      = diff_q;
  assign bout      = flags_q.bout;
  assign zero      = flags_q.zero;
  assign neg       = flags_q.neg;
  assign ovf       = flags_q.ovf;

endmodule
